// File: rtl/multicycle_controller.sv
// Main control FSM for the RV32I multicycle datapath. Sequences fetch, decode,
// execute, memory and write-back steps, stalls on the memory-ready handshake
// and traps on unsupported encodings or on a memory access that never completes.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecuteR, StExecuteI,
    StAluWb, StBeq, StJal, StJalr1, StJalr2, StLui, StAuipc, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic       TimeoutEn   = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       wait_state;
  logic       deadline;
  logic       alu_f3_ok;
  logic [2:0] alu_op;

  // Memory-wait detection and the timeout deadline
  always_comb begin
    wait_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    deadline   = TimeoutEn && wait_state && !MemReady && (wait_cnt_q == TimeoutLast);
  end

  // funct3 legality and ALU operation for register/immediate arithmetic
  always_comb begin
    alu_f3_ok = 1'b1;
    alu_op    = 3'b000;
    case (funct3)
      3'b000:  alu_op = (state_q == StExecuteR && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (deadline)      state_d = StTrap;
        else if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = (funct3 == 3'b010) ? StMemAdr : StTrap;
          OpRtype:         state_d = alu_f3_ok ? StExecuteR : StTrap;
          OpItype:         state_d = alu_f3_ok ? StExecuteI : StTrap;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = (funct3 == 3'b000) ? StBeq : StTrap;
          OpJalr:          state_d = (funct3 == 3'b000) ? StJalr1 : StTrap;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (MemReady)      state_d = StMemWb;
        else if (deadline) state_d = StTrap;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (MemReady)      state_d = StFetch;
        else if (deadline) state_d = StTrap;
      end
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalr1:    state_d = StJalr2;
      StJalr2:    state_d = StAluWb;
      StLui:      state_d = StFetch;
      StAuipc:    state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // Wait counter: cleared on every transition, saturates so a disabled timeout never wraps
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (wait_state && !MemReady && wait_cnt_q != 8'hff) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Datapath controls decoded from state and instruction fields
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;

    case (op)
      OpLoad, OpItype, OpJalr: ImmSrc = 3'b000;
      OpStore:                 ImmSrc = 3'b001;
      OpBranch:                ImmSrc = 3'b010;
      OpJal:                   ImmSrc = 3'b011;
      OpLui, OpAuipc:          ImmSrc = 3'b100;
      default:                 ImmSrc = 3'b000;
    endcase

    case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        // Held until the memory accepts; dropped on the cycle that times out
        MemWrite = !deadline;
      end
      StExecuteR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
      end
      StExecuteI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      StAluWb:    RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero;
      end
      StJal, StJalr2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      StJalr1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StLui: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      StAuipc: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StTrap:     Illegal = 1'b1;
      default:    Illegal = 1'b1;
    endcase

    // No write strobe may escape while reset is held
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance without timeout and
// one with MEM_TIMEOUT=4 share all inputs; outputs are packed and compared
// against hand-written per-cycle vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0;
  logic [2:0] alu0, imm0;
  logic       pcw4, adr4, mw4, irw4, rw4, ill4;
  logic [1:0] rs4, sa4, sb4;
  logic [2:0] alu4, imm4;

  logic [17:0] o0, o4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(0)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0), .ImmSrc(imm0),
    .RegWrite(rw0), .Illegal(ill0)
  );

  multicycle_controller #(.MEM_TIMEOUT(4)) u_dut4 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(pcw4), .AdrSrc(adr4), .MemWrite(mw4), .IRWrite(irw4),
    .ResultSrc(rs4), .ALUSrcA(sa4), .ALUSrcB(sb4), .ALUControl(alu4), .ImmSrc(imm4),
    .RegWrite(rw4), .Illegal(ill4)
  );

  assign o0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, ill0};
  assign o4 = {pcw4, adr4, mw4, irw4, rs4, sa4, sb4, alu4, imm4, rw4, ill4};

  // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc
  // RegWrite Illegal
  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Check both instances at the negedge, then advance to just after the next posedge
  task automatic cyc(input string tag, input logic [17:0] exp);
    @(negedge clk);
    check_eq({tag, "/t0"}, 32'(o0), 32'(exp));
    check_eq({tag, "/t4"}, 32'(o4), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    op       = ins[6:0];
    funct3   = ins[14:12];
    funct7b5 = ins[30];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    MemReady = 1'b1;
    Zero     = 1'b0;
    set_instr(32'h0020A223);  // sw x2,4(x1)
    repeat (2) @(posedge clk);
    #1;

    // Reset held with MemReady=1: FETCH controls, strobes forced off
    cyc("rst_hold", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0));
    reset = 1'b1;

    // sw up to MEMWRITE, stalled, then reset mid-write
    cyc("sw_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0));
    cyc("sw_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 0, 0));
    cyc("sw_adr",   pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
    MemReady = 1'b0;
    cyc("sw_wr0",   pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0));
    cyc("sw_wr1",   pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0));
    reset = 1'b0;
    #1;
    check_eq("rst_memwrite", 32'(mw0), 32'd0);
    check_eq("rst_abort/t0", 32'(o0),
             32'(pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0)));
    check_eq("rst_abort/t4", 32'(o4),
             32'(pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0)));
    MemReady = 1'b1;
    cyc("rst_rdy",  pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0));
    reset = 1'b1;

    // add x3,x1,x2
    set_instr(32'h002081B3);
    cyc("add_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("add_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));
    cyc("add_exe",   pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
    cyc("add_wb",    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

    // sub x3,x1,x2
    set_instr(32'h402081B3);
    cyc("sub_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("sub_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));
    cyc("sub_exe",   pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0));
    cyc("sub_wb",    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

    // lw x3,0(x1) with three stalled MEMREAD cycles
    set_instr(32'h0000A183);
    cyc("lw_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("lw_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));
    cyc("lw_adr",   pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("lw_stall", pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
    end
    MemReady = 1'b1;
    cyc("lw_read",  pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
    cyc("lw_wb",    pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

    // beq taken then not taken
    set_instr(32'h00208463);
    Zero = 1'b1;
    cyc("beq1_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010, 0, 0));
    cyc("beq1_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 0));
    cyc("beq1_br",    pk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0));
    Zero = 1'b0;
    cyc("beq0_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010, 0, 0));
    cyc("beq0_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 0));
    cyc("beq0_br",    pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0));

    // jal x1,8
    set_instr(32'h008000EF);
    cyc("jal_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b011, 0, 0));
    cyc("jal_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0, 0));
    cyc("jal_jmp",   pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0, 0));
    cyc("jal_wb",    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 1, 0));

    // jalr x1,0(x1)
    set_instr(32'h000080E7);
    cyc("jalr_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("jalr_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));
    cyc("jalr_1",     pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
    cyc("jalr_2",     pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("jalr_wb",    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

    // lui x5,0x12345
    set_instr(32'h123452B7);
    cyc("lui_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b100, 0, 0));
    cyc("lui_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 0, 0));
    cyc("lui_wb",    pk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1, 0));

    // op=0000000 traps and stays trapped
    set_instr(32'h00000000);
    cyc("trap_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("trap_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cyc("trap_hold", pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1));
    end

    // bne (funct3=001) is unsupported and traps
    do_reset();
    set_instr(32'h00209463);
    cyc("bne_fetch", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010, 0, 0));
    cyc("bne_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 0));
    cyc("bne_trap",  pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 0, 1));

    // Fetch timeout: four stalled cycles then TRAP on the MEM_TIMEOUT=4 instance only
    MemReady = 1'b0;
    set_instr(32'h002081B3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc("to_wait", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    end
    @(negedge clk);
    check_eq("to_trap/t4", 32'(o4),
             32'(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1)));
    check_eq("to_none/t0", 32'(o0),
             32'(pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0)));
    @(posedge clk);
    #1;
    MemReady = 1'b1;
    @(negedge clk);
    check_eq("to_stuck_irw/t4", 32'(irw4), 32'd0);
    check_eq("to_stuck/t4", 32'(o4),
             32'(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1)));
    check_eq("to_late/t0", 32'(o0),
             32'(pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0)));
    @(posedge clk);
    #1;

    // MemReady arriving on the deadline cycle wins
    MemReady = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc("to2_wait", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    end
    MemReady = 1'b1;
    cyc("to2_ready", pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    cyc("to2_dec",   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the RV32I multicycle datapath: PC, IR/OldPC, register file, immediate extender, ALU and a single shared instruction/data memory.
- Decodes the latched instruction fields and drives every datapath select and write strobe, including the 3-bit ImmSrc select of the immediate extender (000 I, 001 S, 010 B, 011 J, 100 U).
- Stalls on a memory-ready handshake.
- Traps on unsupported encodings and on memory timeout.

Parameters:
MEM_TIMEOUT, 0, max cycles to wait for MemReady in a memory state; 0 disables the timeout; otherwise 1..255.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
PCWrite  output  1  PC load enable
AdrSrc  output  1  memory address: 0 PC, 1 Result
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR/OldPC load enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUSrcA  output  2  00 PC, 01 OldPC, 10 A (rs1)
ALUSrcB  output  2  00 WriteData (rs2), 01 ImmExt, 10 constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  3  extender select
RegWrite  output  1  register file write enable
Illegal  output  1  sticky trap flag

Behaviour:
Reset and output timing:
- reset low: state=FETCH, timeout counter=0, Illegal=0.
- While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
- Reset asserted mid-instruction aborts it; no strobe fires after reset asserts.
- Outputs are combinational from state, op, funct3, funct7b5, Zero and MemReady.
- Unlisted outputs in a state are 0.

ImmSrc (decoded from op in every state):
- I for 0000011, 0010011, 1100111.
- S for 0100011.
- B for 1100011.
- J for 1101111.
- U for 0110111, 0010111.
- 000 otherwise.

States (next state in brackets):
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. If MemReady: IRWrite=1, PCWrite=1 [DECODE]; else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut = OldPC+imm). Routing by op:
  - lw/sw → MEMADR
  - R-type 0110011 → EXECUTER
  - I-ALU 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - 1100111 → JALR1
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → TRAP
  - Also TRAP: lw/sw with funct3≠010, beq with funct3≠000, jalr with funct3≠000, R/I-ALU with funct3 not in {000,010,110,111}.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add [MEMREAD if op=0000011, else MEMWRITE].
- MEMREAD: AdrSrc=1, ResultSrc=00; wait for MemReady [MEMWB].
- MEMWB: ResultSrc=01, RegWrite=1 [FETCH].
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 held every cycle until MemReady [FETCH].
- EXECUTER: ALUSrcA=10, ALUSrcB=00 [ALUWB]. ALU operation by funct3:
  - 000: sub if funct7b5 else add
  - 010: slt
  - 110: or
  - 111: and
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, same funct3 map but 000 is always add [ALUWB].
- ALUWB: ResultSrc=00, RegWrite=1 [FETCH].
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero [FETCH].
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 [ALUWB].
- JALR1: ALUSrcA=10, ALUSrcB=01, add [JALR2].
- JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 [ALUWB].
- LUI: ResultSrc=11, RegWrite=1 [FETCH].
- AUIPC: ALUSrcA=01, ALUSrcB=01, add [ALUWB].
- TRAP: Illegal=1, all strobes 0. Exit only via reset.

Timeout:
- The 8-bit counter increments each cycle spent in FETCH/MEMREAD/MEMWRITE with MemReady=0.
- It clears on any state change.
- If MEM_TIMEOUT≠0 and count reaches MEM_TIMEOUT-1 with MemReady still 0, next state is TRAP; no strobe fires that cycle.
- MemReady=1 on the deadline cycle wins over the timeout.

Cycle counts with MemReady tied 1:
- R-type, I-ALU, beq, lui: 3–4 cycles (lui 3; R, I-ALU 4; beq 3).
- auipc, jal: 4.
- sw: 4.
- lw, jalr: 5.

Test Plan:
- Reset low mid-MEMWRITE with MemReady=0 → MemWrite drops to 0 immediately; after release, state FETCH, Illegal=0, PCWrite=1 on first cycle with MemReady=1.
- add x3,x1,x2 (0x002081B3), MemReady=1 → FETCH, DECODE, EXECUTER (ALUControl=000, ALUSrcB=00), ALUWB (RegWrite=1); sub variant (funct7b5=1) → ALUControl=001.
- lw (0x0000A183), MemReady low for 3 cycles in MEMREAD → state held 3 cycles, then MEMWB with ResultSrc=01, RegWrite=1; ImmSrc=000 throughout.
- beq with Zero=1 then Zero=0 → PCWrite=1 / 0 in BEQ state, ImmSrc=010; jal → ImmSrc=011, PCWrite in JAL, RegWrite in next ALUWB.
- lui (0x123452B7) → ImmSrc=100, ResultSrc=11, RegWrite=1 in third cycle; op=0000000 → TRAP, Illegal=1 held until reset.
- MEM_TIMEOUT=4, MemReady=0 in FETCH → TRAP after 4 FETCH cycles, IRWrite never asserted; repeat with MemReady=1 on 4th cycle → DECODE.
